// File: rtl/ifu_prefetch.sv
// ----------------------------------------------------------------------------
// ifu_prefetch - prefetching instruction fetch unit
//
// Issues sequential word fetches starting at RESET_PC, keeps up to
// MAX_OUTSTANDING reads in flight and queues returned instructions (with their
// PCs) in a DEPTH-entry FIFO toward decode. A redirect flushes the FIFO,
// restarts fetch at redirect_pc and discards every response still owed for
// requests issued before the redirect.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   redirect_valid  redirect the fetch stream this cycle
//   redirect_pc     new fetch PC (low bits passed through untouched)
//   mem_req_valid   read request valid
//   mem_req_ready   memory accepts the request
//   mem_req_addr    read address (current fetch PC)
//   mem_resp_valid  read data valid, in request order, one per request
//   mem_resp_data   read data
//   inst_valid      FIFO head valid
//   inst_ready      decode accepts the head
//   inst_data       head instruction
//   inst_pc         head PC
//
// Optional feature (macro IFU_PERF_EN):
//   perf_fetch_cnt  saturating count of delivered instructions
//   perf_bubble_cnt saturating count of cycles decode was ready but starved
// ----------------------------------------------------------------------------
module ifu_prefetch #(
    parameter int unsigned      XLEN            = 32,
    parameter logic [XLEN-1:0]  RESET_PC        = 32'h8000_0000,
    parameter int unsigned      DEPTH           = 4,
    parameter int unsigned      MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [31:0]     mem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     fifo_count;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;

    logic [31:0]     data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic fifo_empty;
    logic credit_ok;
    logic room_ok;
    logic req_fire;
    logic resp_take;
    logic push;
    logic pop;

    // ------------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_count = wr_ptr - rd_ptr;

    // Every live (non-dropped) in-flight request already owns a FIFO slot.
    assign credit_ok = (32'(fifo_count) + 32'(outstanding) - 32'(drop_cnt)) < DEPTH;
    assign room_ok   = 32'(outstanding) < MAX_OUTSTANDING;

    // Gating with rst keeps the request line low while reset is held; the
    // first request can go out in the first cycle after release.
    assign mem_req_valid = rst && !redirect_valid && room_ok && credit_ok;
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Responses with nothing outstanding are spurious and ignored.
    assign resp_take = mem_resp_valid && (outstanding != '0);
    assign push      = resp_take && (drop_cnt == '0) && !redirect_valid;

    assign inst_valid = !fifo_empty;
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = inst_valid ? data_mem[rd_ptr[AW-1:0]] : '0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr[AW-1:0]]   : '0;

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // A response landing in the redirect cycle is itself stale, so it
            // is already settled and not counted toward the drop budget.
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= outstanding - OW'(resp_take);
            drop_cnt    <= outstanding - OW'(resp_take);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            outstanding <= outstanding + OW'(req_fire) - OW'(resp_take);
            if (resp_take && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - OW'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + XLEN'(4);
                wr_ptr  <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // FIFO storage; contents are only observable while the entry is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr[AW-1:0]] <= mem_resp_data;
            pc_mem[wr_ptr[AW-1:0]]   <= resp_pc;
        end
    end

`ifdef IFU_PERF_EN
    // ------------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (pop && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (inst_ready && !inst_valid && (perf_bubble_cnt != '1)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
